// File: rtl/data_cache_controller_if.sv
// Bus bundle between the pipeline memory stage, the data cache and main
// data memory, as seen by data_cache_controller.
//   slave  : controller side (takes requests, drives stall/cache/memory)
//   master : environment side (pipeline + cache + memory models)
// Signals:
//   reqValid/reqWrite/reqAddress/reqWriteData : pipeline request
//   stall                                      : pipeline freeze
//   cacheHit, cacheAddress, cacheWriteData,
//   cacheWriteFromMemory, cacheWriteEnable     : cache port
//   memReq, memWrite, memAddress, memWriteData,
//   memReadData, memAck                        : memory port
interface data_cache_controller_if;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        stall;
    logic        cacheHit;
    logic [31:0] cacheAddress;
    logic [31:0] cacheWriteData;
    logic        cacheWriteFromMemory;
    logic        cacheWriteEnable;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memAck;

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqWriteData, cacheHit,
               memReadData, memAck,
        output stall, cacheAddress, cacheWriteData, cacheWriteFromMemory,
               cacheWriteEnable, memReq, memWrite, memAddress, memWriteData
    );

    modport master (
        output reqValid, reqWrite, reqAddress, reqWriteData, cacheHit,
               memReadData, memAck,
        input  stall, cacheAddress, cacheWriteData, cacheWriteFromMemory,
               cacheWriteEnable, memReq, memWrite, memAddress, memWriteData
    );
endinterface

// File: rtl/data_cache_controller.sv
// Miss-handling / write-through controller for a direct-mapped data cache.
// A load miss stalls the pipeline, refills the whole block word by word via
// the cache fill port, then replays the access for one cycle so the cache
// hits. Stores are written through to memory and into the cache on a hit
// (no write-allocate).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : data_cache_controller_if.slave (pipeline, cache, memory signals)
module data_cache_controller #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int BLOCK_BITS      = 6
) (
    input logic                   clk,
    input logic                   reset,
    data_cache_controller_if.slave bus
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] REPLAY = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31-BLOCK_BITS:0] base_q, base_d;
    // Set for the single IDLE cycle after a store is acknowledged. The
    // pipeline still presents that store (it was stalled through the ack),
    // so this cycle retires it without stalling instead of reissuing it.
    logic                   wdone_q, wdone_d;
    logic [31:0]            fill_addr;

    assign fill_addr = {base_q, cnt_q, 2'b00};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wdone_d = 1'b0;

        bus.stall                = 1'b1;
        bus.cacheAddress         = bus.reqAddress;
        bus.cacheWriteData       = bus.reqWriteData;
        bus.cacheWriteFromMemory = 1'b0;
        bus.cacheWriteEnable     = 1'b0;
        bus.memReq               = 1'b0;
        bus.memWrite             = 1'b0;
        bus.memAddress           = '0;
        bus.memWriteData         = '0;

        case (state_q)
            IDLE: begin
                bus.stall = 1'b0;
                if (bus.reqValid) begin
                    if (bus.reqWrite) begin
                        if (!wdone_q) begin
                            bus.stall = 1'b1;
                            state_d   = WRITE;
                        end
                    end else if (!bus.cacheHit) begin
                        bus.stall = 1'b1;
                        base_d    = bus.reqAddress[31:BLOCK_BITS];
                        cnt_d     = '0;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.memReq               = 1'b1;
                bus.memAddress           = fill_addr;
                bus.cacheAddress         = fill_addr;
                bus.cacheWriteData       = bus.memReadData;
                bus.cacheWriteFromMemory = bus.memAck;
                if (bus.memAck) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD)
                        state_d = REPLAY;
                end
            end
            REPLAY: begin
                state_d = IDLE;
            end
            WRITE: begin
                bus.memReq           = 1'b1;
                bus.memWrite         = 1'b1;
                bus.memAddress       = {bus.reqAddress[31:2], 2'b00};
                bus.memWriteData     = bus.reqWriteData;
                bus.cacheWriteEnable = bus.memAck;
                if (bus.memAck) begin
                    state_d = IDLE;
                    wdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            wdone_q <= wdone_d;
        end
    end
endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: models a 4-line direct-mapped cache and a
// word memory; checks stall lengths, memory transactions and cache contents.
module tb_data_cache_controller;
    logic clk = 1'b0;
    logic reset;
    data_cache_controller_if bus();

    data_cache_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference models
    logic [31:0] mem [1024];
    bit          cv [4];
    logic [23:0] ctag [4];
    logic [31:0] cdat [4][16];
    int          cur_lat = 1;
    int          wcnt = 0;

    // per-cycle observations
    logic        o_stall, o_req, o_wr, o_fill, o_cwe, o_ack, o_hit;
    logic [31:0] o_maddr, o_mwd, o_caddr, o_cwd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit lookup(input logic [31:0] a);
        return cv[a[7:6]] && (ctag[a[7:6]] == a[31:8]);
    endfunction

    // Settle, play cache + memory for this cycle, sample, then clock the models.
    task automatic cycle_step();
        #1;
        bus.cacheHit = lookup(bus.cacheAddress);
        #1;
        if (bus.memReq && (wcnt == cur_lat - 1)) begin
            bus.memAck      = 1'b1;
            bus.memReadData = mem[bus.memAddress[11:2]];
        end else begin
            bus.memAck      = 1'b0;
            bus.memReadData = $urandom;
        end
        #1;
        o_stall = bus.stall;   o_req = bus.memReq;  o_wr  = bus.memWrite;
        o_fill  = bus.cacheWriteFromMemory;         o_cwe = bus.cacheWriteEnable;
        o_ack   = bus.memAck;  o_hit = bus.cacheHit;
        o_maddr = bus.memAddress;  o_mwd = bus.memWriteData;
        o_caddr = bus.cacheAddress; o_cwd = bus.cacheWriteData;
        @(posedge clk);
        if (o_fill) begin
            cv[o_caddr[7:6]]   = 1'b1;
            ctag[o_caddr[7:6]] = o_caddr[31:8];
            cdat[o_caddr[7:6]][o_caddr[5:2]] = o_cwd;
        end
        if (o_cwe && o_hit) cdat[o_caddr[7:6]][o_caddr[5:2]] = o_cwd;
        if (o_ack && o_wr) mem[o_maddr[11:2]] = o_mwd;
        if (o_req) wcnt = o_ack ? 0 : wcnt + 1;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        bus.reqValid = 1'b0;
        cycle_step();
    endtask

    // One pipeline access, from presentation until stall drops.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int lat);
        bit   hit0;
        int   exp_stall, stalls, acks, fills, cwes, reqs, n;
        logic [31:0] exp_a, replay_ca;
        hit0 = lookup(addr);
        exp_stall = wr ? 1 + lat : (hit0 ? 0 : 2 + 16 * lat);
        bus.reqValid = 1'b1; bus.reqWrite = wr;
        bus.reqAddress = addr; bus.reqWriteData = data;
        cur_lat = lat; wcnt = 0;
        stalls = 0; acks = 0; fills = 0; cwes = 0; reqs = 0; n = 0;
        replay_ca = '0;
        do begin
            cycle_step();
            n++;
            if (o_req) reqs++;
            if (o_fill) fills++;
            if (o_cwe) cwes++;
            if (o_ack) begin
                exp_a = wr ? {addr[31:2], 2'b00} : {addr[31:6], 4'(acks), 2'b00};
                chk("ack_memAddress", o_maddr, exp_a);
                chk("ack_memWrite", 32'(o_wr), 32'(wr));
                if (wr) chk("ack_memWriteData", o_mwd, data);
                else    chk("fill_cacheAddress", o_caddr, exp_a);
                acks++;
            end
            if (o_stall) begin
                stalls++;
                replay_ca = o_caddr;
            end
        end while (o_stall && n < 2000);
        chk("access_timeout", 32'(n < 2000), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("mem_req_cycles", 32'(reqs), 32'(wr ? lat : (hit0 ? 0 : 16 * lat)));
        chk("mem_acks", 32'(acks), 32'(wr ? 1 : (hit0 ? 0 : 16)));
        chk("fill_strobes", 32'(fills), 32'(wr ? 0 : (hit0 ? 0 : 16)));
        chk("store_strobes", 32'(cwes), 32'(wr ? 1 : 0));
        if (!wr) begin
            chk("load_hits_after", 32'(o_hit), 32'd1);
            chk("load_data", cdat[addr[7:6]][addr[5:2]], mem[addr[11:2]]);
            if (!hit0) chk("replay_cacheAddress", replay_ca, addr);
        end
    endtask

    initial begin
        logic [31:0] a;
        int acks;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i);
        for (int i = 0; i < 4; i++) cv[i] = 1'b0;
        bus.reqValid = 0; bus.reqWrite = 0; bus.reqAddress = 0; bus.reqWriteData = 0;
        bus.cacheHit = 0; bus.memAck = 0; bus.memReadData = 0;
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_memReq", 32'(bus.memReq), 32'd0);
        chk("rst_memWrite", 32'(bus.memWrite), 32'd0);
        chk("rst_fill", 32'(bus.cacheWriteFromMemory), 32'd0);
        chk("rst_cwe", 32'(bus.cacheWriteEnable), 32'd0);
        chk("rst_cacheAddress", bus.cacheAddress, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycle();
        chk("idle_stall", 32'(o_stall), 32'd0);

        // directed sequence
        access(1'b0, 32'h0000_0010, 32'h0, 1);           // miss, 18 stall cycles
        chk("word_index_fill", cdat[0][5], 32'd5);
        access(1'b0, 32'h0000_0010, 32'h0, 1);           // hit
        idle_cycle();
        access(1'b1, 32'h0000_0010, 32'h1234_5678, 2);   // store, 3 stall cycles
        chk("store_mem", mem[4], 32'h1234_5678);
        chk("store_cache", cdat[0][4], 32'h1234_5678);
        access(1'b0, 32'h0000_0410, 32'h0, 3);           // miss, 50 stall cycles
        access(1'b1, 32'h0000_0800, 32'hCAFE_F00D, 1);   // store then load miss back to back
        access(1'b0, 32'h0000_0840, 32'h0, 1);
        idle_cycle();

        // reset in the middle of a refill
        bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddress = 32'h0000_0980;
        cur_lat = 1; wcnt = 0; acks = 0;
        for (int i = 0; i < 40 && acks < 5; i++) begin
            cycle_step();
            if (o_ack) acks++;
        end
        chk("mid_refill_acks", 32'(acks), 32'd5);
        reset = 1'b0; bus.reqValid = 1'b0;
        #1;
        chk("mid_rst_memReq", 32'(bus.memReq), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cv[i] = 1'b0;
        idle_cycle();
        chk("post_rst_stall", 32'(o_stall), 32'd0);
        chk("post_rst_memReq", 32'(o_req), 32'd0);

        // randomized traffic over a small address window to mix hits/misses
        for (int k = 0; k < 40; k++) begin
            a = {22'd0, 2'($urandom), 2'($urandom), 4'($urandom), 2'b00};
            access(1'($urandom), a, $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Miss-handling and write-through controller between the pipeline memory stage, the direct-mapped data cache, and main data memory. Stalls the pipeline on a load miss, refills the full 16-word block word by word into the cache via the cache's memory-fill port, then replays the access so the cache hits. Stores are written through to memory and into the cache when the line is present.

## Interface
- WORDS_PER_BLOCK, 16, words per cache block (power of two; block offset = address[5:2])
- BLOCK_BITS, 6, low address bits covered by one block (word + byte offset)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- reqValid  in  1  pipeline load/store request present
- reqWrite  in  1  1 = store, 0 = load
- reqAddress  in  32  request byte address; held stable while stall=1
- reqWriteData  in  32  store data; held stable while stall=1
- cacheHit  in  1  hit from cache for the current cacheAddress
- stall  out  1  freeze pipeline
- cacheAddress  out  32  address driven to cache
- cacheWriteData  out  32  data driven to cache
- cacheWriteFromMemory  out  1  cache fill strobe (sets valid/tag, writes word)
- cacheWriteEnable  out  1  cache store strobe (cache writes only on hit)
- memReq  out  1  memory request, held until memAck
- memWrite  out  1  1 = memory write, valid with memReq
- memAddress  out  32  word-aligned memory address
- memWriteData  out  32  memory write data
- memReadData  in  32  memory read data, valid on memAck
- memAck  in  1  memory completes current request this cycle

## Operation
- States: IDLE, REFILL, REPLAY, WRITE.
- IDLE: cacheAddress = reqAddress, cacheWriteData = reqWriteData; memReq=0, fill/store strobes 0.
  - reqValid & !reqWrite & cacheHit: no stall, stay IDLE.
  - reqValid & !reqWrite & !cacheHit: stall=1 (combinational, same cycle); latch blockBase = reqAddress[31:6]; counter <= 0; -> REFILL.
  - reqValid & reqWrite: stall=1; -> WRITE.
- REFILL: memReq=1, memWrite=0, memAddress = cacheAddress = {blockBase, counter, 2'b00}; cacheWriteData = memReadData; cacheWriteFromMemory = memAck. On memAck: counter increments; if counter == WORDS_PER_BLOCK-1 -> REPLAY. cacheHit ignored in REFILL.
- REPLAY: one cycle, stall=1, cacheAddress = reqAddress, memReq=0; -> IDLE. Next cycle the cache hits and stall drops.
- WRITE: memReq=1, memWrite=1, memAddress = {reqAddress[31:2],2'b00}, memWriteData = reqWriteData; cacheWriteEnable = memAck (cache updates only if hit; no write-allocate). On memAck -> IDLE.
- stall = 1 in every state except IDLE; in IDLE per rules above.
- Counter 4 bits, wraps 15->0 on the final ack (value irrelevant after).

## Timing
- Reset (reset=0, async): state IDLE, counter 0, blockBase 0; memReq, memWrite, cacheWriteFromMemory, cacheWriteEnable = 0; stall = 0 while reqValid=0. Reset mid-refill aborts immediately: memReq drops without waiting for memAck; a partially filled line is left to the cache's own reset.
- Load hit: 0 stall cycles.
- Load miss, memAck every cycle: 1 (detect) + 16 (fill) + 1 (REPLAY) = 18 stall cycles; in general 2 + sum of per-word memory latencies.
- Store: 1 + memory latency stall cycles; minimum 2.
- memAck while memReq=0 is ignored. memAck is sampled only on rising clk.
- Fill word written into cache on the same edge memAck is sampled.
- Exactly one memory transaction outstanding at any time.

## Test plan
- Reset then reqValid=0 -> all outputs 0, state IDLE; pulse reset=0 mid-REFILL after 5 acks -> memReq=0 immediately, stall=0 after release with reqValid=0.
- Load 0x00000010, cacheHit=0, memAck every cycle, memReadData = word index -> memAddress steps 0x00,0x04..0x3C, 16 fill strobes, stall high exactly 18 cycles, cacheAddress=0x10 in REPLAY.
- Load miss 0x00000410 with memAck every 3rd cycle -> memAddress 0x400..0x43C, memReq held between acks, stall = 2+48 = 50 cycles.
- Load hit 0x00000010 (cacheHit=1) -> stall=0, memReq never asserted.
- Store 0x12345678 to 0x00000010, memAck after 2 cycles -> memWrite=1, memAddress=0x10, memWriteData=0x12345678, cacheWriteEnable pulses once on ack cycle, stall 3 cycles.
- Back-to-back store then load miss -> WRITE completes, IDLE one cycle, then REFILL begins; no overlapping memReq.
